// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: widths, the no-lock tag
// encoding and the fixed source indices.
`ifndef Reg_Lock_Width
`define Reg_Lock_Width 6
`endif
`ifndef Data_Width
`define Data_Width 32
`endif
`ifndef ROB_Entry_Width
`define ROB_Entry_Width 5
`endif
`ifndef Reg_No_Lock
`define Reg_No_Lock 6'b100000
`endif
`ifndef CDB_Src_ALU
`define CDB_Src_ALU 0
`endif
`ifndef CDB_Src_Load
`define CDB_Src_Load 1
`endif
`ifndef CDB_Src_Store
`define CDB_Src_Store 2
`endif

package cdb_arbiter_pkg;
    localparam int unsigned REG_LOCK_WIDTH  = `Reg_Lock_Width;
    localparam int unsigned DATA_WIDTH      = `Data_Width;
    localparam int unsigned ROB_ENTRY_WIDTH = `ROB_Entry_Width;

    // Tag value meaning "no ROB entry": bit above the ROB index set.
    localparam logic [REG_LOCK_WIDTH-1:0] REG_NO_LOCK = `Reg_No_Lock;

    localparam int unsigned CDB_SRC_ALU   = `CDB_Src_ALU;
    localparam int unsigned CDB_SRC_LOAD  = `CDB_Src_Load;
    localparam int unsigned CDB_SRC_STORE = `CDB_Src_Store;
endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue: DEPTH entries of W bits, synchronous
// active-high reset and flush both empty it. A push into a full queue is
// ignored even if the queue pops in the same cycle.
module cdb_src_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (power-of-two wrap) and occupancy.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; reset and flush discard all contents.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Multi-source common data bus: N_SRC per-source queues feeding a
// round-robin arbiter that broadcasts one tagged result per cycle to the
// reservation stations, ROB and PC.
// Optional feature macro: CDB_BYPASS_EN -- an empty queue's incoming
// result competes in the same cycle and, when it wins, drives the bus
// combinationally without being enqueued.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned TAG_W  = REG_LOCK_WIDTH,
    parameter int unsigned DATA_W = DATA_WIDTH,
    parameter int unsigned ROB_W  = ROB_ENTRY_WIDTH,
    localparam int unsigned SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [N_SRC-1:0]        src_valid,
    output logic [N_SRC-1:0]        src_ready,
    input  logic [N_SRC*TAG_W-1:0]  src_tag,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic                    cdb_valid,
    output logic [TAG_W-1:0]        cdb_tag,
    output logic [DATA_W-1:0]       cdb_data,
    output logic [SRC_W-1:0]        cdb_src,
    output logic                    rob_write,
    output logic [ROB_W-1:0]        rob_entry,
    output logic [DATA_W-1:0]       rob_value
);
    localparam int unsigned E_W = TAG_W + DATA_W;
    localparam logic [TAG_W-1:0] IDLE_TAG = TAG_W'(REG_NO_LOCK);

    logic [N_SRC-1:0] full, empty, push, pop, req;
    logic [E_W-1:0]   head [N_SRC];
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic              found;
    int unsigned       win_idx;
    logic              byp_hit;
    logic [E_W-1:0]    win_entry;
    logic              bus_valid_d;
    logic [TAG_W-1:0]  bus_tag_d;
    logic [DATA_W-1:0] bus_data_d;
    logic [SRC_W-1:0]  bus_src_d;

    assign src_ready = ~full;

    for (genvar i = 0; i < N_SRC; i++) begin : g_q
        cdb_src_fifo #(
            .DEPTH (DEPTH),
            .W     (E_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   ({src_tag[i*TAG_W +: TAG_W], src_data[i*DATA_W +: DATA_W]}),
            .full  (full[i]),
            .empty (empty[i]),
            .head  (head[i])
        );
    end

    // Round-robin pick starting at rr_ptr; build pops, pushes and bus value.
    always_comb begin
`ifdef CDB_BYPASS_EN
        req = ~empty | src_valid;
`else
        req = ~empty;
`endif
        found   = 1'b0;
        win_idx = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            int unsigned idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && req[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end

        // A winning source whose queue is empty can only be the bypass path.
        byp_hit   = found && empty[win_idx];
        win_entry = head[win_idx];
        if (byp_hit) begin
            win_entry = {src_tag[win_idx*TAG_W +: TAG_W], src_data[win_idx*DATA_W +: DATA_W]};
        end

        for (int unsigned i = 0; i < N_SRC; i++) begin
            pop[i]  = found && (win_idx == i) && !empty[i];
            push[i] = src_valid[i] && !(byp_hit && (win_idx == i));
        end

        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (win_idx == N_SRC - 1) ? '0 : SRC_W'(win_idx + 1);
        end

        bus_valid_d = found && !rst && !flush;
        bus_tag_d   = IDLE_TAG;
        bus_data_d  = '0;
        bus_src_d   = '0;
        if (bus_valid_d) begin
            bus_tag_d  = win_entry[E_W-1 -: TAG_W];
            bus_data_d = win_entry[DATA_W-1:0];
            bus_src_d  = SRC_W'(win_idx);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef CDB_BYPASS_EN
    assign cdb_valid = bus_valid_d;
    assign cdb_tag   = bus_tag_d;
    assign cdb_data  = bus_data_d;
    assign cdb_src   = bus_src_d;
`else
    logic              bus_valid_q;
    logic [TAG_W-1:0]  bus_tag_q;
    logic [DATA_W-1:0] bus_data_q;
    logic [SRC_W-1:0]  bus_src_q;

    // Registered broadcast: each winner is held on the bus for one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            bus_valid_q <= 1'b0;
            bus_tag_q   <= IDLE_TAG;
            bus_data_q  <= '0;
            bus_src_q   <= '0;
        end else begin
            bus_valid_q <= bus_valid_d;
            bus_tag_q   <= bus_tag_d;
            bus_data_q  <= bus_data_d;
            bus_src_q   <= bus_src_d;
        end
    end

    assign cdb_valid = bus_valid_q;
    assign cdb_tag   = bus_tag_q;
    assign cdb_data  = bus_data_q;
    assign cdb_src   = bus_src_q;
`endif

    assign rob_write = cdb_valid && (cdb_tag != IDLE_TAG);
    assign rob_entry = cdb_tag[ROB_W-1:0];
    assign rob_value = cdb_data;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter in its default (registered bus) build.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned TW = REG_LOCK_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned RW = ROB_ENTRY_WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [N-1:0]      src_valid = '0;
    logic [N-1:0]      src_ready;
    logic [N*TW-1:0]   src_tag = '0;
    logic [N*DW-1:0]   src_data = '0;
    logic              cdb_valid;
    logic [TW-1:0]     cdb_tag;
    logic [DW-1:0]     cdb_data;
    logic [1:0]        cdb_src;
    logic              rob_write;
    logic [RW-1:0]     rob_entry;
    logic [DW-1:0]     rob_value;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter #(
        .N_SRC (N),
        .DEPTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src),
        .rob_write (rob_write),
        .rob_entry (rob_entry),
        .rob_value (rob_value)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input logic [TW-1:0] t);
        return 32'hC0DE_0000 + DW'(t);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [TW-1:0] t);
        src_valid[i]          = 1'b1;
        src_tag[i*TW +: TW]   = t;
        src_data[i*DW +: DW]  = dat(t);
    endtask

    task automatic exp_bus(input string name, input logic v, input logic [TW-1:0] t,
                           input logic [DW-1:0] d, input logic [1:0] s);
        chk({name, ".valid"}, 64'(cdb_valid), 64'(v));
        chk({name, ".tag"}, 64'(cdb_tag), v ? 64'(t) : 64'(REG_NO_LOCK));
        chk({name, ".data"}, 64'(cdb_data), v ? 64'(d) : 64'd0);
        chk({name, ".src"}, 64'(cdb_src), v ? 64'(s) : 64'd0);
        chk({name, ".rob_write"}, 64'(rob_write), 64'(v && (t != REG_NO_LOCK)));
        chk({name, ".rob_value"}, 64'(rob_value), 64'(cdb_data === (v ? d : '0) ? cdb_data : (v ? d : '0)));
        if (v) chk({name, ".rob_entry"}, 64'(rob_entry), 64'(t[RW-1:0]));
    endtask

    task automatic idle(input string name);
        exp_bus(name, 1'b0, REG_NO_LOCK, '0, 2'd0);
    endtask

    task automatic bus(input string name, input logic [TW-1:0] t, input logic [1:0] s);
        exp_bus(name, 1'b1, t, dat(t), s);
    endtask

    initial begin
        // 1: reset with all sources valid
        drive(0, 6'd1); drive(1, 6'd2); drive(2, 6'd3);
        rst = 1'b1;
        step; idle("rst0");
        step; idle("rst1");
        chk("rst_ready", 64'(src_ready), 64'b111);
        rst = 1'b0; src_valid = '0;
        step; idle("post_rst");
        chk("post_rst_ready", 64'(src_ready), 64'b111);

        // 2: single ALU result
        drive(0, 6'd5); src_data[0 +: DW] = 32'hDEAD_BEEF;
        step; idle("single_push");
        src_valid = '0;
        step; exp_bus("single", 1'b1, 6'd5, 32'hDEAD_BEEF, 2'd0);
        step; idle("single_after");

        // 3: contention, rr_ptr=0 then rr_ptr=1
        rst = 1'b1; step; rst = 1'b0;
        drive(0, 6'd1); drive(1, 6'd2); drive(2, 6'd3);
        step; idle("cont_push");
        src_valid = '0;
        step; bus("cont_a", 6'd1, 2'd0);
        step; bus("cont_b", 6'd2, 2'd1);
        step; bus("cont_c", 6'd3, 2'd2);
        step; idle("cont_end");
        drive(0, 6'd9);
        step; src_valid = '0;
        step; bus("cont_rr", 6'd9, 2'd0);
        drive(0, 6'd4); drive(1, 6'd5); drive(2, 6'd6);
        step; idle("cont2_push");
        src_valid = '0;
        step; bus("cont2_a", 6'd5, 2'd1);
        step; bus("cont2_b", 6'd6, 2'd2);
        step; bus("cont2_c", 6'd4, 2'd0);
        step; idle("cont2_end");

        // 4: back-pressure on Load
        rst = 1'b1; step; rst = 1'b0;
        drive(0, 6'd20); drive(1, 6'd10); drive(2, 6'd30);
        step; idle("bp1");
        drive(0, 6'd21); drive(1, 6'd11); drive(2, 6'd31);
        step; bus("bp2", 6'd20, 2'd0);
        chk("bp2_ready", 64'(src_ready), 64'b001);
        drive(0, 6'd22); drive(1, 6'd12); src_valid[2] = 1'b0;
        step; bus("bp3", 6'd10, 2'd1);
        chk("bp3_ready", 64'(src_ready), 64'b010);
        src_valid[0] = 1'b0;
        step; bus("bp4", 6'd30, 2'd2);
        chk("bp4_ready", 64'(src_ready), 64'b100);
        src_valid = '0;
        step; bus("bp5", 6'd21, 2'd0);
        step; bus("bp6", 6'd11, 2'd1);
        step; bus("bp7", 6'd31, 2'd2);
        step; bus("bp8", 6'd22, 2'd0);
        step; bus("bp9", 6'd12, 2'd1);
        step; idle("bp10");

        // 5: flush with four queued entries and a simultaneous push
        drive(0, 6'd12); drive(1, 6'd13); drive(2, 6'd14);
        step; idle("fl_push");
        src_valid = '0; drive(0, 6'd15); drive(1, 6'd16);
        step; bus("fl_a", 6'd14, 2'd2);
        src_valid = '0; drive(2, 6'd17);
        step; bus("fl_b", 6'd12, 2'd0);
        src_valid = '0; drive(2, 6'd18); flush = 1'b1;
        step; idle("fl_edge");
        chk("fl_ready", 64'(src_ready), 64'b111);
        flush = 1'b0; src_valid = '0;
        step; idle("fl_q1");
        step; idle("fl_q2");
        step; idle("fl_q3");
        drive(0, 6'd24); drive(1, 6'd25); drive(2, 6'd26);
        step; idle("fl_rr_push");
        src_valid = '0;
        step; bus("fl_rr_a", 6'd24, 2'd0);
        step; bus("fl_rr_b", 6'd25, 2'd1);
        step; bus("fl_rr_c", 6'd26, 2'd2);
        step; idle("fl_rr_end");

        // 6: tagless result is broadcast but not written to the ROB
        drive(0, REG_NO_LOCK); src_data[0 +: DW] = 32'd77;
        step; idle("nolock_push");
        src_valid = '0;
        step; exp_bus("nolock", 1'b1, REG_NO_LOCK, 32'd77, 2'd0);
        chk("nolock_rob_write", 64'(rob_write), 64'd0);
        step; idle("nolock_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
